// File: rtl/vote_session_controller.sv
`default_nettype none
// ============================================================================
//  Module   : vote_session_controller
//  Purpose  : Sequences one polling session of the EVM. Authorises one ballot
//             per voter, arbitrates the four candidate buttons, keeps four
//             saturating vote counters plus a running total, and on poll
//             close freezes the tallies, waits for the winner stage to
//             settle and then flags results valid.
//  Ports    : clock            - system clock, rising edge
//             reset_n          - asynchronous active-low reset
//             poll_open        - officer level, 1 = polling open
//             ballot_enable    - officer pulse, authorises one voter (IDLE)
//             btn[3:0]         - synchronised candidate buttons, bit0 = c1
//             vote_count_c1..4 - registered candidate tallies
//             total_votes      - registered sum of accepted votes
//             ballot_active    - 1 while a ballot is armed (voter lamp)
//             vote_accepted    - 1-cycle pulse, vote recorded
//             vote_rejected    - 1-cycle pulse, ballot void/timed-out/saturated
//             results_valid    - 1 while results are frozen and settled
//             state[2:0]       - current FSM state code (debug)
//             reject_count     - saturating reject tally (optional)
//  Options  : VOTE_REJECT_COUNT_EN adds the reject_count output and counter.
//  Revision : 1.0 - initial release
// ============================================================================
module vote_session_controller #(
    parameter int COUNT_W        = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int RESULT_LAT     = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               poll_open,
    input  logic               ballot_enable,
    input  logic [3:0]         btn,
    output logic [COUNT_W-1:0] vote_count_c1,
    output logic [COUNT_W-1:0] vote_count_c2,
    output logic [COUNT_W-1:0] vote_count_c3,
    output logic [COUNT_W-1:0] vote_count_c4,
    output logic [COUNT_W+1:0] total_votes,
    output logic               ballot_active,
    output logic               vote_accepted,
    output logic               vote_rejected,
    output logic               results_valid,
    output logic [2:0]         state
`ifdef VOTE_REJECT_COUNT_EN
    ,
    output logic [COUNT_W-1:0] reject_count
`endif
);

    typedef enum logic [2:0] {
        S_CLOSED = 3'd0,
        S_IDLE   = 3'd1,
        S_ARMED  = 3'd2,
        S_RECORD = 3'd3,
        S_TALLY  = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    // One shared wait counter serves both the ARMED timeout and the TALLY
    // settle delay; it is sized for the longer of the two.
    localparam int C_MAX_WAIT = (TIMEOUT_CYCLES > RESULT_LAT) ? TIMEOUT_CYCLES : RESULT_LAT;
    localparam int C_CNT_W    = $clog2(C_MAX_WAIT + 1);

    localparam logic [C_CNT_W-1:0] C_TIMEOUT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_RESULT_LAST  = C_CNT_W'(RESULT_LAT - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE      = C_CNT_W'(1);
    localparam logic [COUNT_W-1:0] C_COUNT_MAX    = '1;
    localparam logic [COUNT_W-1:0] C_COUNT_ONE    = COUNT_W'(1);
    localparam logic [COUNT_W+1:0] C_TOTAL_ONE    = (COUNT_W + 2)'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_btn_q;
    logic [3:0]           w_rise;
    logic [2:0]           w_rise_cnt;
    logic [1:0]           w_rise_idx;
    logic [1:0]           r_sel;
    logic [C_CNT_W-1:0]   r_wait_cnt;
    logic [COUNT_W-1:0]   r_count [0:3];
    logic [COUNT_W+1:0]   r_total;
    logic                 r_accepted;
    logic                 r_rejected;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_latch;
    logic                 w_sel_sat;

    // ------------------------------------------------------------------
    // Button edge detection; only meaningful while ARMED.
    // ------------------------------------------------------------------
    always_comb begin
        w_rise     = btn & ~r_btn_q;
        w_rise_cnt = {2'b00, w_rise[0]} + {2'b00, w_rise[1]}
                   + {2'b00, w_rise[2]} + {2'b00, w_rise[3]};
        w_rise_idx = 2'd0;
        if (w_rise[0])      w_rise_idx = 2'd0;
        else if (w_rise[1]) w_rise_idx = 2'd1;
        else if (w_rise[2]) w_rise_idx = 2'd2;
        else if (w_rise[3]) w_rise_idx = 2'd3;
        w_sel_sat = (r_count[r_sel] == C_COUNT_MAX);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_CLOSED;
        else          r_state <= w_state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state and decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            S_CLOSED: begin
                if (poll_open) w_state_next = S_IDLE;
            end
            S_IDLE: begin
                // Closing the poll wins over a simultaneous ballot request.
                if (!poll_open)         w_state_next = S_TALLY;
                else if (ballot_enable) w_state_next = S_ARMED;
            end
            S_ARMED: begin
                // A closing poll does not abort an armed ballot.
                if (w_rise_cnt == 3'd1) begin
                    w_latch      = 1'b1;
                    w_state_next = S_RECORD;
                end else if (w_rise_cnt >= 3'd2) begin
                    w_reject     = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_wait_cnt == C_TIMEOUT_LAST) begin
                    w_reject     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_RECORD: begin
                w_state_next = S_IDLE;
                if (w_sel_sat) w_reject = 1'b1;
                else           w_accept = 1'b1;
            end
            S_TALLY: begin
                if (r_wait_cnt == C_RESULT_LAST) w_state_next = S_RESULT;
            end
            S_RESULT: begin
                if (poll_open) w_state_next = S_IDLE;
            end
            default: w_state_next = S_CLOSED;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: edge register, wait counter, tallies and pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_q    <= 4'd0;
            r_wait_cnt <= '0;
            r_sel      <= 2'd0;
            r_total    <= '0;
            r_accepted <= 1'b0;
            r_rejected <= 1'b0;
            for (int i = 0; i < 4; i++) r_count[i] <= '0;
        end else begin
            r_btn_q    <= btn;
            r_accepted <= w_accept;
            r_rejected <= w_reject;
            // Cleared on every state change so each ARMED/TALLY visit starts at 0.
            if (w_state_next != r_state)
                r_wait_cnt <= '0;
            else if (r_state == S_ARMED || r_state == S_TALLY)
                r_wait_cnt <= r_wait_cnt + C_CNT_ONE;
            if (w_latch) r_sel <= w_rise_idx;
            if (w_accept) begin
                r_count[r_sel] <= r_count[r_sel] + C_COUNT_ONE;
                r_total        <= r_total + C_TOTAL_ONE;
            end
        end
    end

`ifdef VOTE_REJECT_COUNT_EN
    logic [COUNT_W-1:0] r_reject_cnt;

    // Rejections only arise in ARMED/RECORD, so the count is frozen in TALLY/RESULT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_reject_cnt <= '0;
        else if (w_reject && r_reject_cnt != C_COUNT_MAX)
            r_reject_cnt <= r_reject_cnt + C_COUNT_ONE;
    end

    assign reject_count = r_reject_cnt;
`endif

    assign vote_count_c1 = r_count[0];
    assign vote_count_c2 = r_count[1];
    assign vote_count_c3 = r_count[2];
    assign vote_count_c4 = r_count[3];
    assign total_votes   = r_total;
    assign vote_accepted = r_accepted;
    assign vote_rejected = r_rejected;
    assign ballot_active = (r_state == S_ARMED);
    assign results_valid = (r_state == S_RESULT);
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vote_session_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vote_session_controller
//  Purpose  : Self-checking bench for vote_session_controller. A cycle-level
//             reference model derived from the session rules is compared
//             with every DUT output on each falling clock edge; directed
//             scenarios add hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vote_session_controller;

    localparam int C_COUNT_W = 8;
    localparam int C_TIMEOUT = 8;
    localparam int C_RL      = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        poll_open = 1'b0;
    logic        ballot_enable = 1'b0;
    logic [3:0]  btn = 4'd0;
    logic [7:0]  vote_count_c1, vote_count_c2, vote_count_c3, vote_count_c4;
    logic [9:0]  total_votes;
    logic        ballot_active, vote_accepted, vote_rejected, results_valid;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    vote_session_controller #(
        .COUNT_W        (C_COUNT_W),
        .TIMEOUT_CYCLES (C_TIMEOUT),
        .RESULT_LAT     (C_RL)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .poll_open     (poll_open),
        .ballot_enable (ballot_enable),
        .btn           (btn),
        .vote_count_c1 (vote_count_c1),
        .vote_count_c2 (vote_count_c2),
        .vote_count_c3 (vote_count_c3),
        .vote_count_c4 (vote_count_c4),
        .total_votes   (total_votes),
        .ballot_active (ballot_active),
        .vote_accepted (vote_accepted),
        .vote_rejected (vote_rejected),
        .results_valid (results_valid),
        .state         (state)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: session rules expressed on plain integers.
    // Phases: 0 closed, 1 idle, 2 armed, 3 record, 4 tally, 5 result.
    // ------------------------------------------------------------------
    int         m_state, m_age, m_cand, m_total, m_acc, m_rej;
    int         m_cnt [4];
    logic [3:0] m_btn_prev;

    task automatic model_reset();
        m_state = 0; m_age = 0; m_cand = 0; m_total = 0; m_acc = 0; m_rej = 0;
        m_btn_prev = 4'd0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endtask

    task automatic model_step();
        logic [3:0] rise;
        int         presses;
        rise       = btn & ~m_btn_prev;
        m_btn_prev = btn;
        presses    = $countones(rise);
        m_acc      = 0;
        m_rej      = 0;
        case (m_state)
            0: if (poll_open == 1'b1) m_state = 1;
            1: begin
                if (poll_open == 1'b0) begin
                    m_state = 4; m_age = 0;
                end else if (ballot_enable == 1'b1) begin
                    m_state = 2; m_age = 0;
                end
            end
            2: begin
                if (presses == 1) begin
                    for (int k = 0; k < 4; k++) if (rise[k]) m_cand = k;
                    m_state = 3;
                end else if (presses >= 2 || m_age == C_TIMEOUT - 1) begin
                    m_rej = 1; m_state = 1;
                end else begin
                    m_age++;
                end
            end
            3: begin
                if (m_cnt[m_cand] < 255) begin
                    m_cnt[m_cand]++; m_total++; m_acc = 1;
                end else begin
                    m_rej = 1;
                end
                m_state = 1;
            end
            4: begin
                if (m_age == C_RL - 1) m_state = 5;
                else                   m_age++;
            end
            5: if (poll_open == 1'b1) m_state = 1;
            default: m_state = 0;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (reset_n == 1'b0) model_reset();
            else                 model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            check("cyc_state",  int'(state),         m_state);
            check("cyc_active", int'(ballot_active), (m_state == 2) ? 1 : 0);
            check("cyc_valid",  int'(results_valid), (m_state == 5) ? 1 : 0);
            check("cyc_acc",    int'(vote_accepted), m_acc);
            check("cyc_rej",    int'(vote_rejected), m_rej);
            check("cyc_c1",     int'(vote_count_c1), m_cnt[0]);
            check("cyc_c2",     int'(vote_count_c2), m_cnt[1]);
            check("cyc_c3",     int'(vote_count_c3), m_cnt[2]);
            check("cyc_c4",     int'(vote_count_c4), m_cnt[3]);
            check("cyc_total",  int'(total_votes),   m_total);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Enable, press, release; samples the result pulse after the record cycle.
    task automatic cast_vote(input logic [3:0] pat, output int acc, output int rej);
        ballot_enable = 1'b1;
        tick();
        ballot_enable = 1'b0;
        btn = pat;
        tick();
        btn = 4'd0;
        tick();
        acc = int'(vote_accepted);
        rej = int'(vote_rejected);
    endtask

    // Counts ARMED cycles until the ballot ends, bounded.
    task automatic armed_cycles(output int n);
        n = 0;
        while (ballot_active == 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int acc, rej, n;
        repeat (3) tick();
        check("rst_state",  int'(state), 0);
        check("rst_total",  int'(total_votes), 0);
        check("rst_c1",     int'(vote_count_c1), 0);
        check("rst_active", int'(ballot_active), 0);
        check("rst_valid",  int'(results_valid), 0);
        reset_n = 1'b1;
        tick();
        check("closed_hold", int'(state), 0);
        poll_open = 1'b1;
        tick();
        check("open_idle", int'(state), 1);

        // Single valid vote for c1
        cast_vote(4'b0001, acc, rej);
        check("v1_acc",   acc, 1);
        check("v1_rej",   rej, 0);
        check("v1_c1",    int'(vote_count_c1), 1);
        check("v1_total", int'(total_votes), 1);

        // Two buttons in the same cycle void the ballot
        ballot_enable = 1'b1;
        tick();
        ballot_enable = 1'b0;
        check("mp_active", int'(ballot_active), 1);
        btn = 4'b0110;
        tick();
        check("mp_rej",   int'(vote_rejected), 1);
        check("mp_state", int'(state), 1);
        check("mp_c2",    int'(vote_count_c2), 0);
        check("mp_c3",    int'(vote_count_c3), 0);
        check("mp_total", int'(total_votes), 1);
        btn = 4'd0;
        tick();
        check("mp_pulse_len", int'(vote_rejected), 0);

        // Timeout with no press
        ballot_enable = 1'b1;
        tick();
        ballot_enable = 1'b0;
        armed_cycles(n);
        check("to_cycles", n, 8);
        check("to_rej",    int'(vote_rejected), 1);
        check("to_total",  int'(total_votes), 1);

        // Button held before arming never counts
        btn = 4'b0100;
        tick();
        ballot_enable = 1'b1;
        tick();
        ballot_enable = 1'b0;
        armed_cycles(n);
        check("held_cycles", n, 8);
        check("held_c3",     int'(vote_count_c3), 0);
        btn = 4'd0;
        tick();

        // Poll closes while armed: ballot completes, then tally and results
        ballot_enable = 1'b1;
        tick();
        ballot_enable = 1'b0;
        poll_open = 1'b0;
        btn = 4'b0010;
        tick();
        check("pc_record", int'(state), 3);
        btn = 4'd0;
        tick();
        check("pc_c2",    int'(vote_count_c2), 1);
        check("pc_acc",   int'(vote_accepted), 1);
        check("pc_idle",  int'(state), 1);
        tick();
        check("pc_tally", int'(state), 4);
        tick();
        check("pc_tally2",    int'(state), 4);
        check("pc_not_valid", int'(results_valid), 0);
        tick();
        check("pc_result", int'(state), 5);
        check("pc_valid",  int'(results_valid), 1);
        repeat (3) tick();
        check("pc_valid_hold", int'(results_valid), 1);
        check("pc_total",      int'(total_votes), 2);
        poll_open = 1'b1;
        tick();
        check("reopen_state", int'(state), 1);
        check("reopen_valid", int'(results_valid), 0);
        check("reopen_c1",    int'(vote_count_c1), 1);
        check("reopen_c2",    int'(vote_count_c2), 1);
        check("reopen_total", int'(total_votes), 2);

        // Asynchronous reset in the middle of an armed ballot
        ballot_enable = 1'b1;
        tick();
        ballot_enable = 1'b0;
        check("ar_armed", int'(state), 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_state",  int'(state), 0);
        check("ar_active", int'(ballot_active), 0);
        check("ar_total",  int'(total_votes), 0);
        check("ar_c1",     int'(vote_count_c1), 0);
        check("ar_c2",     int'(vote_count_c2), 0);
        check("ar_valid",  int'(results_valid), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("ar_reopen", int'(state), 1);

        // Saturation of c3 from a fresh reset
        for (int i = 0; i < 255; i++) begin
            cast_vote(4'b0100, acc, rej);
            check("sat_fill_acc", acc, 1);
        end
        check("sat_fill_c3", int'(vote_count_c3), 255);
        cast_vote(4'b0100, acc, rej);
        check("sat_rej",   rej, 1);
        check("sat_acc",   acc, 0);
        check("sat_c3",    int'(vote_count_c3), 255);
        check("sat_total", int'(total_votes), 255);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
